acc_to_bf16_pipe: RTL

- Multi-lane, pipelined converter from signed fixed-point accumulator words (ACC_W bits, FRAC_BITS fractional) to BF16.
- Sits between the systolic array drain and the BF16 result writeback path.
- Adds features beyond the single-lane combinational converter:
  - parametrised width and lane count;
  - selectable rounding (truncate or round-to-nearest-even);
  - valid/ready flow control with full-throughput stalls;
  - per-lane overflow/underflow flags.

---
 rtl/bf16_pkg.sv | 25 ++
 rtl/lead_zero_count.sv | 19 +
 rtl/acc_to_bf16_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - BF16 field widths, packed format and packing helper.
package bf16_pkg;

  localparam int BF16_BIAS    = 127;
  localparam int BF16_EXP_W   = 8;
  localparam int BF16_MAN_W   = 7;
  localparam int BF16_EXP_MAX = 255;

  typedef struct packed {
    logic                  sign;
    logic [BF16_EXP_W-1:0] exp;
    logic [BF16_MAN_W-1:0] man;
  } bf16_t;

  function automatic bf16_t bf16_pack(input logic sign,
                                      input logic [BF16_EXP_W-1:0] exp,
                                      input logic [BF16_MAN_W-1:0] man);
    bf16_t r;
    r.sign = sign;
    r.exp  = exp;
    r.man  = man;
    return r;
  endfunction

endpackage

// File: rtl/lead_zero_count.sv
// rtl/lead_zero_count.sv - leading-zero count of a W-bit word; all zeros yields W.
module lead_zero_count #(
  parameter int W = 18
) (
  input  logic [W-1:0]             data,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W+1);

  // Scan upward so the highest set bit makes the final assignment.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/acc_to_bf16_pipe.sv
// rtl/acc_to_bf16_pipe.sv - multi-lane two-stage fixed-point accumulator to BF16 converter
// with selectable rounding, valid/ready flow control and per-lane saturation flags.
module acc_to_bf16_pipe
  import bf16_pkg::*;
#(
  parameter int ACC_W     = 18,
  parameter int FRAC_BITS = 8,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  input  logic                   round_rne,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*16-1:0]    out_data,
  output logic [LANES-1:0]       out_ovf,
  output logic [LANES-1:0]       out_unf
);

  localparam int LZW = $clog2(ACC_W+1);

  logic s1_valid, s2_valid, s1_adv, s2_adv;

  logic [LANES-1:0]                 sign_c;
  logic [LANES-1:0][ACC_W-1:0]      mag_c;
  logic [LANES-1:0][LZW-1:0]        lz_c;

  logic [LANES-1:0]                 s1_sign;
  logic [LANES-1:0][ACC_W-1:0]      s1_mag;
  logic [LANES-1:0][LZW-1:0]        s1_lz;
  logic                             s1_rne;

  logic [LANES*16-1:0]              res_c;
  logic [LANES-1:0]                 ovf_c, unf_c;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [ACC_W-1:0] acc;

    assign acc       = in_data[i*ACC_W +: ACC_W];
    assign sign_c[i] = acc[ACC_W-1];
    // Unsigned negation keeps the most negative input exact as 2^(ACC_W-1).
    assign mag_c[i]  = acc[ACC_W-1] ? (~acc + ACC_W'(1)) : acc;

    lead_zero_count #(.W(ACC_W)) u_lzc (
      .data  (mag_c[i]),
      .count (lz_c[i])
    );

    logic [ACC_W-2:0] norm_low;
    logic [ACC_W+7:0] ext;
    logic [6:0]       man;
    logic             guard, sticky;
    logic [7:0]       man_inc;
    int               e;
    logic [15:0]      res;
    logic             ovf, unf;

    always_comb begin
      // Drop the leading one; nine zero bits cover p < 7 and give guard/sticky.
      norm_low = (ACC_W-1)'(s1_mag[i] << s1_lz[i]);
      ext      = {norm_low, 9'b0};
      man      = ext[ACC_W+7:ACC_W+1];
      guard    = ext[ACC_W];
      sticky   = |ext[ACC_W-1:0];
      e        = ACC_W - 1 - int'(s1_lz[i]) - FRAC_BITS + BF16_BIAS;
      man_inc  = {1'b0, man} + ((s1_rne && guard && (sticky || man[0])) ? 8'd1 : 8'd0);
      if (man_inc[7]) e = e + 1;
      ovf = 1'b0;
      unf = 1'b0;
      if (s1_mag[i] == '0) begin
        res = 16'h0000;
      end else if (e <= 0) begin
        res = {s1_sign[i], 15'b0};
        unf = 1'b1;
      end else if (e >= BF16_EXP_MAX) begin
        res = bf16_pack(s1_sign[i], 8'hFF, 7'h00);
        ovf = 1'b1;
      end else begin
        res = bf16_pack(s1_sign[i], e[7:0], man_inc[6:0]);
      end
    end

    assign res_c[i*16 +: 16] = res;
    assign ovf_c[i]          = ovf;
    assign unf_c[i]          = unf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_ovf  <= '0;
      out_unf  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= sign_c;
          s1_mag  <= mag_c;
          s1_lz   <= lz_c;
          s1_rne  <= round_rne;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= res_c;
          out_ovf  <= ovf_c;
          out_unf  <= unf_c;
        end
      end
    end
  end

endmodule
